// File: rtl/spi_pkg.sv
// Shared SPI definitions: spcon bit positions, FSM states and bit-order helpers.
// Also imported by spi_master so both ends agree on the control-byte encoding.
package spi_pkg;

  localparam int unsigned SPEN = 0;
  localparam int unsigned CPOL = 1;
  localparam int unsigned CPHA = 2;
  localparam int unsigned LSBF = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_e;

  function automatic logic first_bit(input byte_t b, input logic lsbf);
    return lsbf ? b[0] : b[7];
  endfunction

  function automatic byte_t shift_out(input byte_t b, input logic lsbf);
    return lsbf ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus rise/fall pulses taken
// one register after the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // No reset: the chain simply tracks the pin, so a reset never fakes an edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled pins, mode latched per frame, one-entry tx holding
// buffer and per-byte rx valid pulse. Supports multi-byte frames.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter byte_t       IDLE_TX     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spcon,
  input  logic       sck,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       frame_err,
  output logic       busy
);

  logic sck_rise, sck_fall, ssn_rise, ssn_fall, mosi_s;
  logic sck_lvl_unused, ssn_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  logic unused_spcon;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .pin_i (sck),
    .sync_o(sck_lvl_unused),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ssn_sync (
    .clk   (clk),
    .pin_i (ssn),
    .sync_o(ssn_lvl_unused),
    .rise_o(ssn_rise),
    .fall_o(ssn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk   (clk),
    .pin_i (mosi),
    .sync_o(mosi_s),
    .rise_o(mosi_rise_unused),
    .fall_o(mosi_fall_unused)
  );

  assign unused_spcon = ^spcon[7:4];

  spi_state_e state_q, state_d;
  logic [3:0] mode_q;
  byte_t      buf_q, tx_sr_q, rx_sr_q, rx_data_q, rx_next, tx_next;
  logic       buf_full_q, miso_q, rx_valid_q, tx_underrun_q, frame_err_q;
  logic [2:0] bit_cnt_q;
  logic       cpol, cpha, lsbf, leading, trailing;
  logic       sample_evt, shift_evt, byte_done, reload, frame_err_d;

  assign cpol = mode_q[CPOL];
  assign cpha = mode_q[CPHA];
  assign lsbf = mode_q[LSBF];

  assign leading    = cpol ? sck_fall : sck_rise;
  assign trailing   = cpol ? sck_rise : sck_fall;
  assign sample_evt = (state_q == SHIFT) && (cpha ? trailing : leading);
  assign shift_evt  = (state_q == SHIFT) && (cpha ? leading : trailing);
  assign byte_done  = sample_evt && (bit_cnt_q == 3'd7);
  // A byte completing as ssn rises ends the frame, so no reload for it.
  assign reload     = (state_q == LOAD) || (byte_done && !ssn_rise);
  assign rx_next    = lsbf ? {mosi_s, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s};
  assign tx_next    = buf_full_q ? buf_q : IDLE_TX;
  assign frame_err_d = (state_q == SHIFT) && ssn_rise && (bit_cnt_q != 3'd0) && !byte_done;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ssn_fall && spcon[SPEN]) state_d = LOAD;
      LOAD:    state_d = ssn_rise ? IDLE : SHIFT;
      SHIFT:   if (ssn_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    miso_oe = (state_q != IDLE) && mode_q[SPEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= frame_err_d;
      if (state_q == IDLE && ssn_fall) mode_q <= spcon[3:0];

      if (reload && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (tx_valid && !buf_full_q) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end

      if (shift_evt) begin
        miso_q  <= first_bit(tx_sr_q, lsbf);
        tx_sr_q <= shift_out(tx_sr_q, lsbf);
      end

      if (sample_evt) begin
        rx_sr_q   <= rx_next;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end

      if (reload) begin
        tx_underrun_q <= !buf_full_q;
        // cpha=0 must have the first bit on miso before the first leading edge.
        if (state_q == LOAD && !cpha) begin
          miso_q  <= first_bit(tx_next, lsbf);
          tx_sr_q <= shift_out(tx_next, lsbf);
        end else begin
          tx_sr_q <= tx_next;
        end
        if (state_q == LOAD) bit_cnt_q <= '0;
      end

      if (state_d == IDLE) begin
        miso_q    <= 1'b0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master at clk/8 drives frames
// in several modes; pulse outputs are counted by a negedge monitor.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] spcon = 8'h00;
  logic       sck = 1'b0, ssn = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_valid = 1'b0;

  logic  spen = 1'b1, cpol = 1'b0, cpha = 1'b0, lsbf = 1'b0;
  byte_t mrx;
  int    n_tests = 0, n_fail = 0;
  int    rxv_cnt = 0, und_cnt = 0, ferr_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  int    s_rxv, s_und, s_ferr, s_oe, s_busy;
  logic  s_ready;

  spi_slave #(.SYNC_STAGES(2), .IDLE_TX(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .spcon      (spcon),
    .sck        (sck),
    .ssn        (ssn),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)    rxv_cnt++;
      if (tx_underrun) und_cnt++;
      if (frame_err)   ferr_cnt++;
      if (miso_oe)     oe_cnt++;
      if (busy)        busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_rxv = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt; s_oe = oe_cnt; s_busy = busy_cnt;
    s_ready = tx_ready;
  endtask

  task automatic push(input byte_t b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 50) begin
      wait_clk(1);
      t++;
    end
    n_tests++;
    if (t >= 50) begin
      n_fail++;
      $error("FAIL push_timeout: tx_ready observed %0b expected 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    wait_clk(1);
  endtask

  task automatic frame_start();
    spcon = {4'h0, lsbf, cpha, cpol, spen};
    sck   = cpol;
    wait_clk(4);
    ssn = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    wait_clk(4);
    ssn = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input byte_t mo, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int k;
      k = lsbf ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[k];
        wait_clk(4);
        mrx[k] = miso;
        sck = ~cpol;
        wait_clk(4);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mo[k];
        wait_clk(4);
        mrx[k] = miso;
        sck = cpol;
        wait_clk(4);
      end
    end
  endtask

  initial begin
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);

    // Mode 0, MSB first, A5 preloaded, master sends 3C.
    cpol = 0; cpha = 0; lsbf = 0;
    push(8'hA5);
    check("t1_ready_full", tx_ready, 0);
    snap();
    frame_start();
    check("t1_busy", busy, 1);
    check("t1_miso_oe", miso_oe, 1);
    check("t1_ready_after_load", tx_ready, 1);
    spi_bits(8'h3C, 0, 8);
    frame_end();
    check("t1_master_rx", mrx, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rxv_count", rxv_cnt - s_rxv, 1);
    check("t1_idle_oe", miso_oe, 0);

    // Mode 3, two-byte frame.
    cpol = 1; cpha = 1; lsbf = 0;
    push(8'h12);
    snap();
    frame_start();
    push(8'h34);
    spi_bits(8'hF0, 0, 8);
    check("t2_master_rx0", mrx, 8'h12);
    check("t2_rx_data0", rx_data, 8'hF0);
    check("t2_no_underrun", und_cnt - s_und, 0);
    spi_bits(8'h0F, 0, 8);
    frame_end();
    check("t2_master_rx1", mrx, 8'h34);
    check("t2_rx_data1", rx_data, 8'h0F);
    check("t2_rxv_count", rxv_cnt - s_rxv, 2);

    // Mode 1, LSB first, empty buffer.
    cpol = 0; cpha = 1; lsbf = 1;
    snap();
    frame_start();
    spi_bits(8'h81, 0, 7);
    check("t3_underrun_at_load", und_cnt - s_und, 1);
    spi_bits(8'h81, 7, 1);
    frame_end();
    check("t3_master_rx", mrx, 8'h00);
    check("t3_rx_data", rx_data, 8'h81);
    check("t3_rxv_count", rxv_cnt - s_rxv, 1);

    // Mode 2, ssn raised after 5 bits.
    cpol = 1; cpha = 0; lsbf = 0;
    snap();
    frame_start();
    spi_bits(8'hC3, 0, 5);
    wait_clk(4);
    ssn = 1'b1;
    wait_clk(4);
    check("t4_oe_dropped", miso_oe, 0);
    wait_clk(8);
    check("t4_frame_err", ferr_cnt - s_ferr, 1);
    check("t4_no_rxv", rxv_cnt - s_rxv, 0);
    push(8'h55);
    frame_start();
    spi_bits(8'h55, 0, 8);
    frame_end();
    check("t4_master_rx", mrx, 8'h55);
    check("t4_rx_data", rx_data, 8'h55);

    // spen=0: ssn low and sck toggling must be ignored.
    push(8'h77);
    spen = 0; cpol = 0; cpha = 0; lsbf = 0;
    snap();
    frame_start();
    spi_bits(8'hFF, 0, 4);
    check("t5_oe_mid", miso_oe, 0);
    spi_bits(8'hFF, 4, 4);
    frame_end();
    check("t5_oe_count", oe_cnt - s_oe, 0);
    check("t5_busy_count", busy_cnt - s_busy, 0);
    check("t5_no_rxv", rxv_cnt - s_rxv, 0);
    check("t5_ready_same", tx_ready, s_ready);

    // Reset mid-frame after 3 bits.
    spen = 1;
    frame_start();
    push(8'hAA);
    check("t6_ready_full", tx_ready, 0);
    spi_bits(8'h3C, 0, 3);
    snap();
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("t6_miso", miso, 0);
    check("t6_miso_oe", miso_oe, 0);
    check("t6_tx_ready", tx_ready, 1);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_underrun", tx_underrun, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_busy", busy, 0);
    wait_clk(4);
    ssn = 1'b1;
    wait_clk(8);
    check("t6_no_frame_err", ferr_cnt - s_ferr, 0);
    push(8'h96);
    frame_start();
    spi_bits(8'h69, 0, 8);
    frame_end();
    check("t6_master_rx", mrx, 8'h96);
    check("t6_rx_data_after", rx_data, 8'h69);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) that answers frames from the team's spi_master. It uses the same pin set (sck, ssn, mosi, miso) and the same spcon control-byte encoding.
- All pin inputs are oversampled in the system clk domain. Received bytes are presented with a one-cycle valid pulse.
- Transmit bytes come from a one-entry holding buffer loaded through a valid/ready handshake.
- It sits on the peripheral side of the link and feeds a local register file or FIFO.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck/ssn/mosi (min 2).
- IDLE_TX, 8'h00, byte shifted out when the tx buffer is empty at a byte boundary.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spcon  in  8  control: [0] spen, [1] cpol, [2] cpha, [3] lsbf (1 = LSB first); [7:4] reserved, ignored.
- sck  in  1  SPI clock from master (async).
- ssn  in  1  slave select, active low (async).
- mosi  in  1  master-out data (async).
- miso  out  1  slave-out data.
- miso_oe  out  1  miso drive enable (1 only while selected and spen).
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  8  last received byte, held until next byte completes.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- tx_underrun  out  1  one-cycle pulse: byte boundary with empty buffer, IDLE_TX used.
- frame_err  out  1  one-cycle pulse: ssn deasserted mid-byte.
- busy  out  1  frame in progress.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0, busy=0. Reset clears the holding buffer, shift registers, bit counter and FSM. Reset mid-frame abandons the frame silently; no frame_err.
- Input conditioning:
  - sck, ssn and mosi pass through SYNC_STAGES flops.
  - sck and ssn get one extra register for edge detect.
  - A pin edge is acted on at a fixed latency of SYNC_STAGES+1 clk cycles.
  - Supported sck rate is at most clk/8.
- Edge classes:
  - leading edge = sck transition away from the cpol idle level; trailing edge = the return.
  - cpha=0: sample on leading, shift out on trailing.
  - cpha=1: shift out on leading, sample on trailing.
- Mode latch: spcon is latched at the ssn falling edge and held for the whole frame. Changes mid-frame have no effect.
- Holding buffer: tx_valid && tx_ready stores tx_data and drops tx_ready the next cycle. tx_ready rises again the cycle after the buffer transfers into the shift register.
- FSM states:
  - IDLE: miso_oe=0, busy=0. The ssn falling edge with latched spen=1 goes to LOAD. spen=0 stays in IDLE and ignores sck.
  - LOAD (1 cycle): tx shift register <= buffer (or IDLE_TX plus a tx_underrun pulse); bit_cnt=0; miso_oe=1; busy=1. For cpha=0, miso <= first bit (MSB, or LSB if lsbf). Then go to SHIFT.
  - SHIFT:
    - On a sampling edge: rx shift register takes synced mosi (MSB-first fills from bit 0 shifting left; lsbf fills from bit 7 shifting right), and bit_cnt increments.
    - On a shifting edge: miso <= next bit. For cpha=1, the first shifting edge of each byte presents bit 0 of the sequence.
    - On the 8th sample: rx_data <= assembled byte, rx_valid pulses, bit_cnt wraps to 0, and the tx register reloads from the buffer (or IDLE_TX plus tx_underrun) in the same cycle. For cpha=0, the new first bit goes out on the following trailing edge. Frames of any number of bytes are supported this way.
    - ssn rising edge with bit_cnt=0 goes to IDLE with no pulse. With bit_cnt≠0, frame_err pulses, the partial byte is discarded, and the FSM goes to IDLE.
- IDLE actions: miso_oe=0 and miso=0 on entry.
- Simultaneous events: tx handshake in the same cycle as a reload is ignored for that reload; the byte stays buffered for the next boundary. An ssn rise in the same cycle as the 8th sample completes the byte (rx_valid) with no frame_err.
- rx_valid is not gated by a consumer; a new byte overwrites rx_data.

Decomposition:
- spi_pkg:
  - spcon bit-index constants (SPEN, CPOL, CPHA, LSBF); reused by spi_master.
  - spi_state_e {IDLE, LOAD, SHIFT}.
  - byte_t typedef.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instanced for sck and ssn; mosi uses its synchronized output only.

Test Plan:
- Mode 0, MSB first, bench master at clk/8; tx 8'hA5 preloaded; master sends 8'h3C → master receives 8'hA5, single rx_valid with rx_data=8'h3C, tx_ready back to 1 after LOAD.
- Mode 3, two-byte frame; tx 8'h12, then 8'h34 offered while the first byte shifts; master sends 8'hF0, 8'h0F → master gets 12,34; two rx_valid pulses (F0, 0F); no tx_underrun.
- Mode 1, lsbf=1, empty buffer; master sends 8'h81 → miso shifts 8'h00, one tx_underrun at LOAD, rx_data=8'h81.
- ssn raised after 5 bits of a Mode 2 byte → frame_err one pulse, no rx_valid, miso_oe=0 within SYNC_STAGES+2 clk; next frame (8'h55 both ways) correct.
- spen=0 with ssn low and 8 sck pulses → miso_oe stays 0, no rx_valid, busy stays 0, tx_ready unchanged.
- rst high for one cycle after 3 bits of a frame → all outputs at reset values next cycle, tx_ready=1, no frame_err; next full frame passes.
